// File: rtl/ex_muldiv_sequencer_pkg.sv
// Package for the MIPS multiply/divide sequencer.
// Holds the R-type function codes, the FSM state encoding, the op-kind
// selectors and a decode helper shared by the top and the bench.
package ex_muldiv_sequencer_pkg;

    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;

    // Op kind driven into the shared iteration datapath.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // True for the four codes that launch a multi-cycle sequence.
    function automatic logic is_muldiv(input logic [5:0] func);
        return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
               (func == FUNC_DIV)  || (func == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// Interface between ID/EX and the multiply/divide sequencer.
// master: pipeline side (drives i_start, i_function, i_rs_reg, i_rt_reg;
//         receives o_stall, o_busy, o_done, o_hi, o_lo)
// slave : sequencer side (the reverse)
interface ex_muldiv_sequencer_if #(
    parameter int NB_BITS     = 32,
    parameter int NB_FUNCTION = 6
);
    logic                   i_start;
    logic [NB_FUNCTION-1:0] i_function;
    logic [NB_BITS-1:0]     i_rs_reg;
    logic [NB_BITS-1:0]     i_rt_reg;
    logic                   o_stall;
    logic                   o_busy;
    logic                   o_done;
    logic [NB_BITS-1:0]     o_hi;
    logic [NB_BITS-1:0]     o_lo;

    modport master (
        output i_start, i_function, i_rs_reg, i_rt_reg,
        input  o_stall, o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_function, i_rs_reg, i_rt_reg,
        output o_stall, o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_sequencer_muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   op_div  in  OP_MUL / OP_DIV
//   acc_in  in  2*NB_BITS  multiply: {product hi, product lo / multiplier}
//                           divide  : {remainder, dividend / quotient}
//   opnd    in  NB_BITS    multiplicand or divisor
//   acc_out out 2*NB_BITS  accumulator after this iteration
module muldiv_step #(
    parameter int NB_BITS = 32
) (
    input  logic                   op_div,
    input  logic [2*NB_BITS-1:0]   acc_in,
    input  logic [NB_BITS-1:0]     opnd,
    output logic [2*NB_BITS-1:0]   acc_out
);
    logic [NB_BITS-1:0] addend;
    logic [NB_BITS:0]   sum;
    logic [NB_BITS:0]   part_rem;
    logic [NB_BITS+1:0] diff;

    always_comb begin
        // Shift-add: the carry of the upper-half add becomes the new MSB.
        addend   = acc_in[0] ? opnd : {NB_BITS{1'b0}};
        sum      = {1'b0, acc_in[2*NB_BITS-1:NB_BITS]} + {1'b0, addend};
        // Restoring divide: remainder shifted left with the next dividend bit
        // needs one extra bit before the trial subtract.
        part_rem = {acc_in[2*NB_BITS-1:NB_BITS], acc_in[NB_BITS-1]};
        diff     = {1'b0, part_rem} - {2'b00, opnd};
        if (op_div) begin
            if (!diff[NB_BITS+1])
                acc_out = {diff[NB_BITS-1:0], acc_in[NB_BITS-2:0], 1'b1};
            else
                acc_out = {part_rem[NB_BITS-1:0], acc_in[NB_BITS-2:0], 1'b0};
        end else begin
            acc_out = {sum, acc_in[NB_BITS-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Radix-2 shift-add multiply / restoring divide, one bit per cycle;
// MTHI/MTLO write HI/LO in one cycle from IDLE.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous reset, active low
//   bus    slave side of ex_muldiv_sequencer_if (start/function/operands in,
//          stall/busy/done/HI/LO out)
// Build option: MULDIV_EARLY_TERM_EN ends a multiply RUN as soon as the
// remaining multiplier bits are zero (only o_done timing changes).
import ex_muldiv_sequencer_pkg::*;

module ex_muldiv_sequencer #(
    parameter int NB_BITS     = 32,
    parameter int NB_FUNCTION = 6,
    parameter int NB_CNT      = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ex_muldiv_sequencer_if.slave  bus
);
    localparam logic [NB_CNT-1:0] CNT_N = NB_CNT'(NB_BITS);
    localparam int MSB = NB_BITS - 1;

    state_t                 state, state_nxt;
    logic [NB_CNT-1:0]      cnt;
    logic [2*NB_BITS-1:0]   acc, step_acc;
    logic [NB_BITS-1:0]     opnd_lo, opnd_b, hi, lo;
    logic                   op_div, sgn_q, sgn_r, done;

    logic                   start_md, f_div, f_signed, fix_div, early_hit;
    logic [NB_BITS-1:0]     rs, rt, abs_rs, abs_rt;
    logic [NB_BITS-1:0]     lat_lo, lat_b, res_hi, res_lo;
    logic                   lat_sq, lat_sr;
    logic [2*NB_BITS-1:0]   prod_fix;

    assign rs       = bus.i_rs_reg;
    assign rt       = bus.i_rt_reg;
    assign start_md = (state == S_IDLE) && bus.i_start && is_muldiv(bus.i_function);
    assign f_div    = (bus.i_function == FUNC_DIV)  || (bus.i_function == FUNC_DIVU);
    assign f_signed = (bus.i_function == FUNC_MULT) || (bus.i_function == FUNC_DIV);
    // Signed divide by zero keeps the raw operands and skips the sign fix.
    assign fix_div  = f_signed && (rt != '0);
    assign abs_rs   = rs[MSB] ? -rs : rs;
    assign abs_rt   = rt[MSB] ? -rt : rt;

    // Operand/sign capture for the issuing instruction.
    always_comb begin
        lat_lo = rt;
        lat_b  = rs;
        lat_sq = 1'b0;
        lat_sr = 1'b0;
        if (f_div) begin
            lat_lo = fix_div ? abs_rs : rs;
            lat_b  = fix_div ? abs_rt : rt;
            lat_sq = fix_div && (rs[MSB] ^ rt[MSB]);
            lat_sr = fix_div && rs[MSB];
        end else if (f_signed) begin
            lat_lo = abs_rt;
            lat_b  = abs_rs;
            lat_sq = rs[MSB] ^ rt[MSB];
        end
    end

    muldiv_step #(.NB_BITS(NB_BITS)) u_step (
        .op_div  (op_div),
        .acc_in  (acc),
        .opnd    (opnd_b),
        .acc_out (step_acc)
    );

`ifdef MULDIV_EARLY_TERM_EN
    // The low cnt bits of the lower half are the unconsumed multiplier bits.
    assign early_hit = (state == S_RUN) && (op_div == OP_MUL) &&
                       ((acc[NB_BITS-1:0] << (CNT_N - cnt)) == '0);
`else
    assign early_hit = 1'b0;
`endif

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = sgn_q ? -acc : acc;
        if (op_div == OP_DIV) begin
            res_lo = sgn_q ? -acc[NB_BITS-1:0] : acc[NB_BITS-1:0];
            res_hi = sgn_r ? -acc[2*NB_BITS-1:NB_BITS] : acc[2*NB_BITS-1:NB_BITS];
        end else begin
            res_lo = prod_fix[NB_BITS-1:0];
            res_hi = prod_fix[2*NB_BITS-1:NB_BITS];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_md) state_nxt = S_PREP;
            S_PREP: state_nxt = S_RUN;
            S_RUN:  if (cnt == NB_CNT'(1) || early_hit) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd_lo <= '0;
            opnd_b  <= '0;
            op_div  <= OP_MUL;
            sgn_q   <= 1'b0;
            sgn_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_md) begin
                        op_div  <= f_div ? OP_DIV : OP_MUL;
                        opnd_lo <= lat_lo;
                        opnd_b  <= lat_b;
                        sgn_q   <= lat_sq;
                        sgn_r   <= lat_sr;
                    end else if (bus.i_start && bus.i_function == FUNC_MTHI) begin
                        hi <= rs;
                    end else if (bus.i_start && bus.i_function == FUNC_MTLO) begin
                        lo <= rs;
                    end
                end
                S_PREP: begin
                    acc <= {{NB_BITS{1'b0}}, opnd_lo};
                    cnt <= CNT_N;
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
                    acc <= early_hit ? (acc >> cnt) : step_acc;
                end
                S_FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The issuing instruction is stalled in its own cycle as well.
    assign bus.o_stall = (state != S_IDLE) || start_md;
    assign bus.o_busy  = (state != S_IDLE);
    assign bus.o_done  = done;
    assign bus.o_hi    = hi;
    assign bus.o_lo    = lo;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;
    import ex_muldiv_sequencer_pkg::*;

    localparam int NB = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    ex_muldiv_sequencer_if #(.NB_BITS(NB), .NB_FUNCTION(6)) bus ();

    ex_muldiv_sequencer #(.NB_BITS(NB), .NB_FUNCTION(6), .NB_CNT(6)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Architectural result of each op, straight from MIPS semantics.
    task automatic ref_model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                             output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p;
        longint unsigned up;
        int qa, qb;
        hi = '0; lo = '0;
        case (f)
            FUNC_MULTU: begin
                up = longint'({32'b0, rs}) * longint'({32'b0, rt});
                {hi, lo} = up;
            end
            FUNC_MULT: begin
                sa = longint'($signed(rs));
                sb = longint'($signed(rt));
                p  = sa * sb;
                {hi, lo} = p;
            end
            FUNC_DIVU: begin
                if (rt == 0) begin lo = 32'hFFFF_FFFF; hi = rs; end
                else begin lo = rs / rt; hi = rs % rt; end
            end
            default: begin
                if (rt == 0) begin lo = 32'hFFFF_FFFF; hi = rs; end
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'h0;
                end else begin
                    qa = $signed(rs); qb = $signed(rt);
                    lo = qa / qb; hi = qa % qb;
                end
            end
        endcase
    endtask

    // Edges from the issuing edge (counted as 1) to HI/LO update.
    function automatic int ref_latency(input logic [5:0] f, input logic [31:0] rt);
`ifdef MULDIV_EARLY_TERM_EN
        logic [31:0] m;
        int k;
        if (f == FUNC_MULT || f == FUNC_MULTU) begin
            m = (f == FUNC_MULT && rt[31]) ? -rt : rt;
            k = 0;
            for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
            return ((k + 1 < 32) ? k + 1 : 32) + 3;
        end
        return NB + 3;
`else
        return (f == 6'h3F && rt == 32'h0) ? 0 : NB + 3;
`endif
    endfunction

    task automatic do_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         input bit inject);
        logic [31:0] eh, el;
        int edges, stalls, lat;
        ref_model(f, rs, rt, eh, el);
        lat = ref_latency(f, rt);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_function = f; bus.i_rs_reg = rs; bus.i_rt_reg = rt;
        #1 chk("stall_issue", 64'(bus.o_stall), 64'd1);
        @(posedge clk); #1;
        // Operands must already be captured: scramble them.
        bus.i_start = 1'b0; bus.i_rs_reg = $urandom; bus.i_rt_reg = $urandom;
        edges = 1; stalls = 1;
        while (!bus.o_done && edges < 200) begin
            if (bus.o_stall) stalls++;
            if (inject && edges == 5) begin
                bus.i_start = 1'b1; bus.i_function = FUNC_MULT;
                bus.i_rs_reg = 32'h1234_5678; bus.i_rt_reg = 32'h9;
            end else if (inject && edges == 6) begin
                bus.i_start = 1'b1; bus.i_function = FUNC_MTHI; bus.i_rs_reg = 32'hDEAD_BEEF;
            end else begin
                bus.i_start = 1'b0;
            end
            @(posedge clk); #1; edges++;
        end
        bus.i_start = 1'b0;
        chk("done_seen", 64'(bus.o_done), 64'd1);
        chk("latency", 64'(edges), 64'(lat));
        chk("stall_cycles", 64'(stalls), 64'(lat));
        chk("hi", 64'(bus.o_hi), 64'(eh));
        chk("lo", 64'(bus.o_lo), 64'(el));
        exp_hi = eh; exp_lo = el;
        @(posedge clk); #1;
        chk("done_pulse", 64'(bus.o_done), 64'd0);
        chk("idle_after", 64'(bus.o_busy), 64'd0);
        chk("hilo_hold", {bus.o_hi, bus.o_lo}, {exp_hi, exp_lo});
    endtask

    task automatic do_mt(input logic [5:0] f, input logic [31:0] v);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_function = f; bus.i_rs_reg = v;
        #1 chk("mt_no_stall", 64'(bus.o_stall), 64'd0);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        if (f == FUNC_MTHI) exp_hi = v;
        if (f == FUNC_MTLO) exp_lo = v;
        chk("mt_hilo", {bus.o_hi, bus.o_lo}, {exp_hi, exp_lo});
        chk("mt_busy", 64'(bus.o_busy), 64'd0);
        chk("mt_done", 64'(bus.o_done), 64'd0);
    endtask

    initial begin
        logic [5:0]  fn;
        logic [31:0] a, b;
        bus.i_start = 1'b0; bus.i_function = '0; bus.i_rs_reg = '0; bus.i_rt_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(bus.o_hi), 64'd0);
        chk("rst_lo", 64'(bus.o_lo), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_stall", 64'(bus.o_stall), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        @(negedge clk) rst = 1'b1;

        do_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        do_op(FUNC_MULT, -32'sd7, 32'd6, 1'b0);
        do_op(FUNC_DIV, -32'sd15, 32'd4, 1'b0);
        do_op(FUNC_DIVU, 32'd15, 32'd4, 1'b0);
        do_op(FUNC_DIVU, 32'd55, 32'd0, 1'b0);
        do_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(FUNC_DIV, -32'sd9, 32'd0, 1'b0);
        do_op(FUNC_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(FUNC_MULTU, 32'd77, 32'd0, 1'b0);
        do_op(FUNC_MULTU, 32'd123, 32'd456, 1'b1);

        do_mt(FUNC_MTHI, 32'd9);
        do_mt(FUNC_MTLO, 32'hCAFE_0001);
        // Unrelated function code with i_start: nothing happens.
        do_mt(6'b100000, $urandom);

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_function = FUNC_DIV; bus.i_rs_reg = 32'd1000; bus.i_rt_reg = 32'd7;
        @(posedge clk); #1 bus.i_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_hi", 64'(bus.o_hi), 64'd0);
        chk("mid_rst_lo", 64'(bus.o_lo), 64'd0);
        chk("mid_rst_busy", 64'(bus.o_busy), 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_done", 64'(bus.o_done), 64'd0);
        @(negedge clk) rst = 1'b1;
        exp_hi = '0; exp_lo = '0;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_idle", {32'(bus.o_busy), bus.o_lo}, 64'd0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(3))
                0: fn = FUNC_MULT;
                1: fn = FUNC_MULTU;
                2: fn = FUNC_DIV;
                default: fn = FUNC_DIVU;
            endcase
            a = $urandom; b = $urandom;
            case ($urandom_range(3))
                0: ;
                1: b = $urandom_range(15) - 8;
                2: b = '0;
                default: if (i % 4 == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            endcase
            do_op(fn, a, b, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
